// File: rtl/auth_responder_mq.sv
// ============================================================================
// Module   : auth_responder_mq
// Purpose  : Queued SPDM-style request responder with answer-unit handshake,
//            per-type timeouts and USB control-transfer response fields.
//            Optional Busy-response mode: define AUTH_BUSY_RESP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module auth_responder_mq #(
  parameter int          MSG_W  = 512,
  parameter int          DEPTH  = 4,
  parameter logic [31:0] T_DIG  = 32'd1000,
  parameter logic [31:0] T_CERT = 32'd2000,
  parameter logic [31:0] T_CHAL = 32'd4000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [MSG_W-1:0]    req_msg_i,
  input  logic [1:0]          req_slot_i,
  output logic                ans_start_o,
  output logic [7:0]          ans_type_o,
  output logic [7:0]          ans_param1_o,
  output logic [MSG_W-1:0]    ans_msg_o,
  input  logic                ans_done_i,
  input  logic                ans_err_i,
  input  logic [31:0]         ans_header_i,
  input  logic [MSG_W-33:0]   ans_payload_i,
  input  logic [15:0]         ans_wlength_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ack_i,
  output logic [31:0]         rsp_header_o,
  output logic [MSG_W-33:0]   rsp_payload_o,
  output logic [1:0]          rsp_slot_o,
  output logic [7:0]          bmRequestType_o,
  output logic [7:0]          bRequest_o,
  output logic [15:0]         wLength_o,
  output logic [31:0]         current_timeout_o
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int EW  = MSG_W + 2;
  localparam int PLW = MSG_W - 32;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_DECODE    = 6'b000010,
    S_WAIT_ANS  = 6'b000100,
    S_BUILD_ERR = 6'b001000,
    S_SEND      = 6'b010000,
    S_WAIT_ACK  = 6'b100000
  } state_t;

  state_t state_q, state_d;

  // ------------------------------------------------------------------------
  // Request FIFO
  // ------------------------------------------------------------------------
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;

  assign full  = (count_q == C_DEPTH);
  assign empty = (count_q == '0);
  assign push  = req_valid_i && !full;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_msg_i, req_slot_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Busy tracking: a push into a full queue is dropped but remembered
  // ------------------------------------------------------------------------
  logic       busy_pending;
  logic [1:0] busy_slot;

`ifdef AUTH_BUSY_RESP_EN
  logic       busy_q;
  logic [1:0] busy_slot_q;

  assign req_ready_o  = 1'b1;
  assign busy_pending = busy_q;
  assign busy_slot    = busy_slot_q;

  // A fresh drop wins over the clear taken on the IDLE -> BUILD_ERR edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= 1'b0;
      busy_slot_q <= '0;
    end else if (req_valid_i && full) begin
      busy_q      <= 1'b1;
      busy_slot_q <= req_slot_i;
    end else if ((state_q == S_IDLE) && busy_q) begin
      busy_q      <= 1'b0;
    end
  end
`else
  assign req_ready_o  = !reset && !full;
  assign busy_pending = 1'b0;
  assign busy_slot    = 2'b00;
`endif

  // ------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ------------------------------------------------------------------------
  logic [MSG_W-1:0] work_msg_q, work_msg_d;
  logic [1:0]       work_slot_q, work_slot_d;
  logic [7:0]       err_code_q, err_code_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      cur_to_q, cur_to_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_header_q, rsp_header_d;
  logic [PLW-1:0]   rsp_payload_q, rsp_payload_d;
  logic [1:0]       rsp_slot_q, rsp_slot_d;
  logic [7:0]       bm_q, bm_d;
  logic [7:0]       breq_q, breq_d;
  logic [15:0]      wlen_q, wlen_d;

  logic [7:0]       hdr_ver, hdr_type;
  logic [31:0]      t_sel;

  assign hdr_ver  = work_msg_q[MSG_W-1 -: 8];
  assign hdr_type = work_msg_q[MSG_W-9 -: 8];

  always_comb begin
    case (hdr_type)
      8'h81:   t_sel = T_DIG;
      8'h82:   t_sel = T_CERT;
      default: t_sel = T_CHAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      work_msg_q    <= '0;
      work_slot_q   <= '0;
      err_code_q    <= '0;
      timer_q       <= '0;
      cur_to_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_header_q  <= '0;
      rsp_payload_q <= '0;
      rsp_slot_q    <= '0;
      bm_q          <= '0;
      breq_q        <= '0;
      wlen_q        <= '0;
    end else begin
      state_q       <= state_d;
      work_msg_q    <= work_msg_d;
      work_slot_q   <= work_slot_d;
      err_code_q    <= err_code_d;
      timer_q       <= timer_d;
      cur_to_q      <= cur_to_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_header_q  <= rsp_header_d;
      rsp_payload_q <= rsp_payload_d;
      rsp_slot_q    <= rsp_slot_d;
      bm_q          <= bm_d;
      breq_q        <= breq_d;
      wlen_q        <= wlen_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    work_msg_d    = work_msg_q;
    work_slot_d   = work_slot_q;
    err_code_d    = err_code_q;
    timer_d       = timer_q;
    cur_to_d      = cur_to_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_header_d  = rsp_header_q;
    rsp_payload_d = rsp_payload_q;
    rsp_slot_d    = rsp_slot_q;
    bm_d          = bm_q;
    breq_d        = breq_q;
    wlen_d        = wlen_q;
    ans_start_o   = 1'b0;
    pop           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (busy_pending) begin
          // Busy error reports the slot of the dropped request.
          err_code_d  = 8'h03;
          work_slot_d = busy_slot;
          state_d     = S_BUILD_ERR;
        end else if (!empty) begin
          pop         = 1'b1;
          work_msg_d  = head[EW-1:2];
          work_slot_d = head[1:0];
          state_d     = S_DECODE;
        end
      end

      S_DECODE: begin
        if (hdr_ver != 8'h01) begin
          err_code_d = 8'h02;
          state_d    = S_BUILD_ERR;
        end else if ((hdr_type == 8'h81) || (hdr_type == 8'h82) || (hdr_type == 8'h83)) begin
          ans_start_o = 1'b1;
          timer_d     = t_sel;
          cur_to_d    = t_sel;
          state_d     = S_WAIT_ANS;
        end else begin
          err_code_d = 8'h01;
          state_d    = S_BUILD_ERR;
        end
      end

      S_WAIT_ANS: begin
        if (ans_err_i) begin
          err_code_d = 8'h01;
          state_d    = S_BUILD_ERR;
        end else if (ans_done_i) begin
          rsp_header_d  = ans_header_i;
          rsp_payload_d = ans_payload_i;
          rsp_slot_d    = work_slot_q;
          case (hdr_type)
            8'h81: begin bm_d = 8'd128; breq_d = 8'd24; wlen_d = 16'd260;       end
            8'h83: begin bm_d = 8'd0;   breq_d = 8'd25; wlen_d = 16'd32;        end
            default: begin bm_d = 8'd0; breq_d = 8'd25; wlen_d = ans_wlength_i; end
          endcase
          state_d = S_SEND;
        end else if (timer_q == 32'd0) begin
          err_code_d = 8'h04;
          state_d    = S_BUILD_ERR;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      S_BUILD_ERR: begin
        rsp_header_d  = {8'h01, 8'h7F, err_code_q, 8'h00};
        rsp_payload_d = '0;
        rsp_slot_d    = work_slot_q;
        bm_d          = 8'd0;
        breq_d        = 8'd25;
        wlen_d        = 16'd4;
        state_d       = S_SEND;
      end

      S_SEND: begin
        rsp_valid_d = 1'b1;
        state_d     = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (rsp_ack_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ans_type_o        = hdr_type;
  assign ans_param1_o      = work_msg_q[MSG_W-17 -: 8];
  assign ans_msg_o         = work_msg_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_header_o      = rsp_header_q;
  assign rsp_payload_o     = rsp_payload_q;
  assign rsp_slot_o        = rsp_slot_q;
  assign bmRequestType_o   = bm_q;
  assign bRequest_o        = breq_q;
  assign wLength_o         = wlen_q;
  assign current_timeout_o = cur_to_q;

endmodule

`default_nettype wire

// File: tb/tb_auth_responder_mq.sv
// ============================================================================
// Module   : tb_auth_responder_mq
// Purpose  : Directed self-checking bench for auth_responder_mq.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_auth_responder_mq;

  localparam int MSG_W = 64;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [MSG_W-1:0]  req_msg = '0;
  logic [1:0]        req_slot = '0;
  logic              ans_start;
  logic [7:0]        ans_type, ans_param1;
  logic [MSG_W-1:0]  ans_msg;
  logic              ans_done = 1'b0, ans_err = 1'b0;
  logic [31:0]       ans_header = '0;
  logic [MSG_W-33:0] ans_payload = '0;
  logic [15:0]       ans_wlength = '0;
  logic              rsp_valid;
  logic              rsp_ack = 1'b0;
  logic [31:0]       rsp_header;
  logic [MSG_W-33:0] rsp_payload;
  logic [1:0]        rsp_slot;
  logic [7:0]        bm, breq;
  logic [15:0]       wlen;
  logic [31:0]       cur_to;

  auth_responder_mq #(.MSG_W(MSG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_msg_i(req_msg), .req_slot_i(req_slot),
    .ans_start_o(ans_start), .ans_type_o(ans_type), .ans_param1_o(ans_param1),
    .ans_msg_o(ans_msg), .ans_done_i(ans_done), .ans_err_i(ans_err),
    .ans_header_i(ans_header), .ans_payload_i(ans_payload), .ans_wlength_i(ans_wlength),
    .rsp_valid_o(rsp_valid), .rsp_ack_i(rsp_ack), .rsp_header_o(rsp_header),
    .rsp_payload_o(rsp_payload), .rsp_slot_o(rsp_slot),
    .bmRequestType_o(bm), .bRequest_o(breq), .wLength_o(wlen),
    .current_timeout_o(cur_to)
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               lat;
  bit               started;
  logic [7:0]       seen_type, seen_p1;
  logic [MSG_W-1:0] seen_msg;
  int               stray;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] hdr, input logic [1:0] slot);
    int n = 0;
    req_msg   = {hdr, 24'h5A5A5A, 6'd0, slot};
    req_slot  = slot;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    check("push ready", req_ready, 1);
    step();
    req_valid = 1'b0;
  endtask

  // mode 0: no answer, 1: ans_done, 2: ans_err (one cycle after ans_start)
  task automatic do_req(input logic [31:0] hdr, input logic [1:0] slot, input int mode,
                        input logic [31:0] ahdr, input logic [15:0] awl,
                        output int lat_o, output bit started_o);
    push(hdr, slot);
    lat_o = 1;
    started_o = 1'b0;
    while (!rsp_valid && lat_o < 6000) begin
      if (ans_start) begin
        started_o = 1'b1;
        seen_type = ans_type;
        seen_p1   = ans_param1;
        seen_msg  = ans_msg;
        if (mode != 0) begin
          step();
          lat_o++;
          ans_header  = ahdr;
          ans_payload = 32'hCAFEF00D;
          ans_wlength = awl;
          if (mode == 1) ans_done = 1'b1;
          else           ans_err  = 1'b1;
        end
      end
      step();
      lat_o++;
      ans_done = 1'b0;
      ans_err  = 1'b0;
    end
    check("rsp valid arrives", rsp_valid, 1);
  endtask

  task automatic ack(input string tag);
    rsp_ack = 1'b1;
    step();
    rsp_ack = 1'b0;
    check({tag, " valid drop"}, rsp_valid, 0);
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] eh, input logic [1:0] es);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    check({tag, " valid"}, rsp_valid, 1);
    check({tag, " hdr"}, rsp_header, eh);
    check({tag, " slot"}, rsp_slot, es);
    ack(tag);
  endtask

  initial begin
    // Reset state
    step();
`ifdef AUTH_BUSY_RESP_EN
    check("ready in reset", req_ready, 1);
`else
    check("ready in reset", req_ready, 0);
`endif
    step();
    reset = 1'b0;
    step();
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_header", rsp_header, 0);
    check("rst wLength", wlen, 0);
    check("rst timeout", cur_to, 0);
    check("rst ans_start", ans_start, 0);
    check("rst ready", req_ready, 1);

    // Digest request answered the cycle after ans_start
    do_req(32'h01810000, 2'd1, 1, 32'h01010000, 16'h0000, lat, started);
    check("dig latency", lat, 5);
    check("dig started", started, 1);
    check("dig ans_type", seen_type, 8'h81);
    check("dig ans_msg", seen_msg, {32'h01810000, 24'h5A5A5A, 6'd0, 2'd1});
    check("dig hdr", rsp_header, 32'h01010000);
    check("dig payload", rsp_payload, 32'hCAFEF00D);
    check("dig bm", bm, 128);
    check("dig breq", breq, 24);
    check("dig wlen", wlen, 260);
    check("dig timeout", cur_to, 1000);
    check("dig slot", rsp_slot, 1);
    step();
    step();
    check("dig hold valid", rsp_valid, 1);
    check("dig hold hdr", rsp_header, 32'h01010000);
    ack("dig");

    // Bad protocol version
    do_req(32'h02830000, 2'd2, 0, 32'h0, 16'h0, lat, started);
    check("ver started", started, 0);
    check("ver hdr", rsp_header, 32'h017F0200);
    check("ver wlen", wlen, 4);
    check("ver bm", bm, 0);
    check("ver breq", breq, 25);
    check("ver payload", rsp_payload, 0);
    check("ver slot", rsp_slot, 2);
    ack("ver");

    // Unsupported MessageType
    do_req(32'h01850000, 2'd3, 0, 32'h0, 16'h0, lat, started);
    check("type started", started, 0);
    check("type hdr", rsp_header, 32'h017F0100);
    check("type slot", rsp_slot, 3);
    ack("type");

    // Answer unit flags Invalid Request
    do_req(32'h01820000, 2'd0, 2, 32'h0, 16'h0, lat, started);
    check("aerr started", started, 1);
    check("aerr hdr", rsp_header, 32'h017F0100);
    ack("aerr");

    // Certificate: wLength comes from the answer unit
    do_req(32'h01824400, 2'd2, 1, 32'h01020000, 16'h0123, lat, started);
    check("cert p1", seen_p1, 8'h44);
    check("cert hdr", rsp_header, 32'h01020000);
    check("cert bm", bm, 0);
    check("cert breq", breq, 25);
    check("cert wlen", wlen, 16'h0123);
    check("cert timeout", cur_to, 2000);
    ack("cert");

    // Challenge answered
    do_req(32'h01830000, 2'd3, 1, 32'h01030000, 16'h0777, lat, started);
    check("chal hdr", rsp_header, 32'h01030000);
    check("chal wlen", wlen, 32);
    check("chal timeout", cur_to, 4000);
    ack("chal");

    // Challenge never answered: timer expiry
    do_req(32'h01830000, 2'd1, 0, 32'h0, 16'h0, lat, started);
    check("tmo started", started, 1);
    check("tmo latency", lat, 4006);
    check("tmo hdr", rsp_header, 32'h017F0400);
    check("tmo slot", rsp_slot, 1);
    ack("tmo");

    // Stall rsp_ack and fill the queue behind the current response
    do_req(32'h01810000, 2'd0, 1, 32'h01010000, 16'h0, lat, started);
    push(32'h02810000, 2'd3);
    push(32'h01990000, 2'd1);
    push(32'h03000000, 2'd0);
    push(32'h01000000, 2'd2);
`ifdef AUTH_BUSY_RESP_EN
    check("full ready", req_ready, 1);
    push(32'h01810000, 2'd2);
`else
    check("full ready", req_ready, 0);
`endif
    step();
    step();
    check("stall hdr", rsp_header, 32'h01010000);
    check("stall valid", rsp_valid, 1);
    ack("stall");
`ifdef AUTH_BUSY_RESP_EN
    get_rsp("busy", 32'h017F0300, 2'd2);
`endif
    get_rsp("q0", 32'h017F0200, 2'd3);
    get_rsp("q1", 32'h017F0100, 2'd1);
    get_rsp("q2", 32'h017F0200, 2'd0);
    get_rsp("q3", 32'h017F0100, 2'd2);
    for (int i = 0; i < 10; i++) step();
    check("drained", rsp_valid, 0);

    // Reset while waiting for ack with three requests queued
    push(32'h02000000, 2'd3);
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    check("pre-rst valid", rsp_valid, 1);
    push(32'h02000000, 2'd0);
    push(32'h02000000, 2'd0);
    push(32'h02000000, 2'd0);
    reset = 1'b1;
    step();
    check("mid-rst valid", rsp_valid, 0);
    check("mid-rst hdr", rsp_header, 0);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp_valid || ans_start) stray++;
    end
    check("no stray rsp", stray, 0);
    do_req(32'h01850000, 2'd2, 0, 32'h0, 16'h0, lat, started);
    check("post-rst hdr", rsp_header, 32'h017F0100);
    check("post-rst slot", rsp_slot, 2);
    ack("post-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/auth_responder_mq.md
AUTH_RESPONDER_MQ -- requirements
Module: auth_responder_mq

Interface
REQ-001 Parameter MSG_W, default 512: request/response message width in bits; MSG_W >= 64.
REQ-002 Parameter DEPTH, default 4: request queue depth, power of two, 2..16.
REQ-003 Parameter T_DIG/T_CERT/T_CHAL, defaults 1000/2000/4000: answer timeout in clk cycles per request type, 32-bit.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 req_valid/req_ready  in/out  1/1  request push handshake; transfer when both high.
REQ-007 req_msg  in  MSG_W  request; bits [MSG_W-1 -: 32] = header {ProtocolVersion, MessageType, Param1, Param2}, MSB byte first.
REQ-008 req_slot  in  2  certificate slot tag, carried with the request.
REQ-009 ans_start  out  1  one-cycle pulse starting the answer unit.
REQ-010 ans_type/ans_param1  out  8/8  MessageType/Param1 of the request being answered; ans_msg out MSG_W holds the full request.
REQ-011 ans_done/ans_err  in  1/1  answer ready / answer unit flags Invalid Request; sampled only in WAIT_ANS.
REQ-012 ans_header/ans_payload/ans_wlength  in  32/MSG_W-32/16  answer contents, valid with ans_done.
REQ-013 rsp_valid/rsp_ack  out/in  1/1  response handshake; response held stable while rsp_valid high.
REQ-014 rsp_header/rsp_payload/rsp_slot  out  32/MSG_W-32/2  response contents.
REQ-015 bmRequestType/bRequest/wLength/current_timeout  out  8/8/16/32  USB control-transfer fields for the response.

Function
REQ-016 Queue: DEPTH-entry FIFO of {req_msg, req_slot}; no same-cycle bypass; full/empty from registered occupancy count (width clog2(DEPTH)+1).
REQ-017 FSM states IDLE, DECODE, WAIT_ANS, BUILD_ERR, SEND, WAIT_ACK; one-hot encoding.
REQ-018 IDLE: busy_pending (REQ-030) has priority -> BUILD_ERR with code 0x03; else FIFO non-empty -> pop head into working register, go DECODE.
REQ-019 DECODE (one cycle): ProtocolVersion != 0x01 -> BUILD_ERR code 0x02; MessageType 0x81/0x82/0x83 -> pulse ans_start, load timer, go WAIT_ANS; any other MessageType -> BUILD_ERR code 0x01.
REQ-020 Timer load: 0x81 -> T_DIG, 0x82 -> T_CERT, 0x83 -> T_CHAL; current_timeout equals loaded value from DECODE until next DECODE.
REQ-021 WAIT_ANS: priority ans_err (-> BUILD_ERR 0x01) > ans_done (capture answer, -> SEND) > timer == 0 (-> BUILD_ERR 0x04); timer decrements once per cycle, never wraps.
REQ-022 Control fields on capture: 0x81 -> 128/24/260; 0x83 -> 0/25/32; 0x82 -> 0/25/ans_wlength.
REQ-023 BUILD_ERR (one cycle): rsp_header = {0x01, 0x7F, code, 0x00}; rsp_payload = 0; bmRequestType 0, bRequest 25, wLength 4; -> SEND.
REQ-024 SEND: assert rsp_valid, -> WAIT_ACK; rsp_valid stays high through WAIT_ACK.
REQ-025 WAIT_ACK: rsp_ack high -> rsp_valid low next cycle, -> IDLE; rsp_ack outside WAIT_ACK ignored.
REQ-026 Latency: request into empty FIFO, idle FSM, ans_done in the cycle after ans_start -> rsp_valid high 5 cycles after push.
REQ-027 rsp_slot = slot of request being answered; Busy error carries the dropped request's slot.
REQ-028 Pushes continue during any FSM state; ordering of responses is strictly FIFO order.

Reset
REQ-029 On reset: FIFO empty, state IDLE, busy_pending 0, timer 0, all outputs 0 except req_ready per REQ-031/032; reset mid-transaction drops queue and in-flight response without emitting one.

Configuration
REQ-030 Macro AUTH_BUSY_RESP_EN defined: req_ready constantly 1 after reset; push while FIFO full is dropped, sets sticky busy_pending and latches its slot (second drop while pending: flag stays set, latest slot kept); busy_pending cleared on entry to BUILD_ERR for code 0x03.
REQ-031 With AUTH_BUSY_RESP_EN, req_ready = 1 in reset as well.
REQ-032 Macro undefined: req_ready = !full (0 during reset); busy_pending logic absent; code 0x03 never generated.

Verification
REQ-033 Push header 0x01810000, ans_done next cycle with header 0x01010000 -> rsp_header 0x01010000, bmRequestType 128, bRequest 24, wLength 260, current_timeout 1000.
REQ-034 Push header 0x02830000 -> no ans_start; rsp_header 0x017F0200, wLength 4.
REQ-035 Push 0x01830000, withhold ans_done -> after 4000 cycles rsp_header 0x017F0400.
REQ-036 Push MessageType 0x85 -> 0x017F0100; push 0x01820000 with ans_err -> 0x017F0100.
REQ-037 AUTH_BUSY_RESP_EN: stall rsp_ack, push DEPTH+1 requests, last slot 2 -> next response after current is 0x017F0300 slot 2, then DEPTH queued responses in order; undefined: req_ready low at full.
REQ-038 Assert reset in WAIT_ACK with 3 queued -> rsp_valid 0 next cycle, no further responses until new push.
